// File: rtl/digiota_stim_gen.sv
// digiota_stim_gen: first-order delta-sigma pulse-density stimulus for the
// DigiOTA differential input pair. One accepted code plays for one frame.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no frame active, vip/vin held at 0, ready for a code
// S_RUN  | playing a frame, cnt_q is the index of the bit on vip/vin
module digiota_stim_gen #(
    parameter int CODE_W    = 8,
    parameter int FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              cm_mode,
    output logic              code_ready,
    input  logic              abort,
    output logic              vip,
    output logic              vin,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                cm_q, cm_d;
    logic                vip_q, vip_d;
    logic                vin_q, vin_d;

    logic                last_bit;
    logic                accept;
    logic [CODE_W:0]     sum;

    assign last_bit   = (cnt_q == CNT_LAST);
    assign code_ready = !abort && ((state_q == S_IDLE) || last_bit);
    assign accept     = code_valid && code_ready;
    assign sum        = {1'b0, acc_q} + {1'b0, code_q};

    assign busy       = (state_q == S_RUN);
    assign frame_done = (state_q == S_RUN) && last_bit;
    assign vip        = vip_q;
    assign vin        = vin_q;

    // Next-state: abort beats accept beats the running accumulator step.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        cm_d    = cm_q;
        vip_d   = vip_q;
        vin_d   = vin_q;
        if (abort) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            vip_d   = 1'b0;
            vin_d   = 1'b0;
        end else if (accept) begin
            // Accumulator restarts at 0, so bit 0 is the carry of 0 + code = 0.
            state_d = S_RUN;
            code_d  = code;
            cm_d    = cm_mode;
            acc_d   = code;
            cnt_d   = '0;
            vip_d   = 1'b0;
            vin_d   = !cm_mode;
        end else if (state_q == S_RUN) begin
            if (last_bit) begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                vip_d   = 1'b0;
                vin_d   = 1'b0;
            end else begin
                acc_d   = sum[CODE_W-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                vip_d   = sum[CODE_W];
                vin_d   = cm_q ? sum[CODE_W] : !sum[CODE_W];
            end
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            cm_q    <= 1'b0;
            vip_q   <= 1'b0;
            vin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            cm_q    <= cm_d;
            vip_q   <= vip_d;
            vin_q   <= vin_d;
        end
    end

endmodule

// File: tb/tb_digiota_stim_gen.sv
// Bench for digiota_stim_gen: expected per-cycle output vectors are queued
// at each accept and popped one per cycle on the falling edge.
module tb_digiota_stim_gen;

    localparam int FL = 256;
    localparam logic [4:0] IDLE_V = 5'b00100; // {busy, fd, ready, vip, vin}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       cm_mode = 1'b0;
    logic       abort = 1'b0;
    logic       code_ready, vip, vin, busy, frame_done;
    logic [4:0] obs;

    int vectors = 0;
    int miscompares = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    assign obs = {busy, frame_done, code_ready, vip, vin};

    digiota_stim_gen #(.CODE_W(8), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .cm_mode(cm_mode), .code_ready(code_ready), .abort(abort),
        .vip(vip), .vin(vin), .busy(busy), .frame_done(frame_done)
    );

    // Reference bit i = floor((i+1)c/256) - floor(ic/256).
    function automatic logic [4:0] model(input int c, input logic cm, input int i);
        int   b;
        logic bb;
        b  = ((i + 1) * c) / 256 - (i * c) / 256;
        bb = b[0];
        return {1'b1, (i == FL - 1), (i == FL - 1), bb, cm ? bb : ~bb};
    endfunction

    task automatic push_frame(input int c, input logic cm);
        for (int i = 0; i < FL; i++) sb_q.push_back(model(c, cm, i));
    endtask

    task automatic test_reset;
        logic [4:0] e;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_state: got %b want %b", obs, IDLE_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        code_valid = 1'b1; code = 8'h40; cm_mode = 1'b0;
        @(posedge clk);
        push_frame(8'h40, 1'b0);
        for (int i = 0; i <= 60; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL pre_reset_frame cyc %0d: got %b want %b", i, obs, e);
            end
        end
        sb_q.delete();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", obs, IDLE_V);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== IDLE_V) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, IDLE_V);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_half_code;
        logic [4:0] e;
        int ones = 0;
        code_valid = 1'b1; code = 8'h80; cm_mode = 1'b0;
        @(posedge clk);
        push_frame(8'h80, 1'b0);
        sb_q.push_back(IDLE_V);
        for (int i = 0; i <= FL; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL half_code cyc %0d: got %b want %b", i, obs, e);
            end
            if (i < FL && vip === 1'b1) ones++;
        end
        vectors++;
        if (ones != 128) begin
            miscompares++;
            $display("FAIL half_code_ones: got %0d want 128", ones);
        end
    endtask

    task automatic test_endpoints;
        logic [4:0] e;
        logic [7:0] codes [3] = '{8'h00, 8'hFF, 8'hC3};
        logic       cms   [3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            int ones = 0;
            code_valid = 1'b1; code = codes[t]; cm_mode = cms[t];
            @(posedge clk);
            push_frame(codes[t], cms[t]);
            sb_q.push_back(IDLE_V);
            for (int i = 0; i <= FL; i++) begin
                @(negedge clk);
                code_valid = 1'b0;
                e = sb_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL endpoint_%0d cyc %0d: got %b want %b", t, i, obs, e);
                end
                if (i < FL && vip === 1'b1) ones++;
            end
            vectors++;
            if (ones != int'(codes[t])) begin
                miscompares++;
                $display("FAIL endpoint_%0d_ones: got %0d want %0d", t, ones, codes[t]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] e;
        logic [7:0] codes [20];
        logic       cms   [20];
        for (int f = 0; f < 20; f++) begin
            codes[f] = 8'($urandom_range(0, 255));
            cms[f]   = 1'($urandom_range(0, 1));
        end
        code_valid = 1'b1; code = codes[0]; cm_mode = cms[0];
        @(posedge clk);
        push_frame(codes[0], cms[0]);
        for (int f = 0; f < 20; f++) begin
            int ones = 0;
            for (int i = 0; i < FL; i++) begin
                @(negedge clk);
                e = sb_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL b2b_f%0d cyc %0d: got %b want %b", f, i, obs, e);
                end
                if (vip === 1'b1) ones++;
                if (i == 0) begin
                    if (f < 19) begin
                        code = codes[f + 1]; cm_mode = cms[f + 1];
                    end else begin
                        code_valid = 1'b0;
                    end
                end
                if (i == FL - 1 && f < 19) push_frame(codes[f + 1], cms[f + 1]);
            end
            vectors++;
            if (ones != int'(codes[f])) begin
                miscompares++;
                $display("FAIL b2b_f%0d_ones: got %0d want %0d", f, ones, codes[f]);
            end
        end
        @(negedge clk);
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL b2b_tail: got %b want %b", obs, IDLE_V);
        end
    endtask

    task automatic test_abort;
        logic [4:0] e;
        int ones = 0;
        code_valid = 1'b1; code = 8'h40; cm_mode = 1'b0;
        @(posedge clk);
        push_frame(8'h40, 1'b0);
        for (int i = 0; i <= 37; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_pre cyc %0d: got %b want %b", i, obs, e);
            end
        end
        sb_q.delete();
        abort = 1'b1; code_valid = 1'b1; code = 8'h99; cm_mode = 1'b1;
        #1;
        vectors++;
        if (code_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ready: got %b want 0", code_ready);
        end
        @(negedge clk);
        vectors++;
        if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_idle: got %b want 00000", obs);
        end
        abort = 1'b0;
        #1;
        vectors++;
        if (obs !== IDLE_V) begin
            miscompares++;
            $display("FAIL abort_release: got %b want %b", obs, IDLE_V);
        end
        @(posedge clk);
        push_frame(8'h99, 1'b1);
        sb_q.push_back(IDLE_V);
        for (int i = 0; i <= FL; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_next cyc %0d: got %b want %b", i, obs, e);
            end
            if (i < FL && vip === 1'b1) ones++;
        end
        vectors++;
        if (ones != 8'h99) begin
            miscompares++;
            $display("FAIL abort_next_ones: got %0d want %0d", ones, 8'h99);
        end
    endtask

    task automatic test_valid_while_busy;
        logic [4:0] e;
        int ones = 0;
        code_valid = 1'b1; code = 8'h33; cm_mode = 1'b1;
        @(posedge clk);
        push_frame(8'h33, 1'b1);
        sb_q.push_back(IDLE_V);
        for (int i = 0; i <= FL; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL busy_valid cyc %0d: got %b want %b", i, obs, e);
            end
            if (i < FL && vip === 1'b1) ones++;
            if (i == 100) begin
                code_valid = 1'b1; code = 8'hEE; cm_mode = 1'b0;
                #1;
                vectors++;
                if (code_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_valid_ready: got %b want 0", code_ready);
                end
            end
        end
        vectors++;
        if (ones != 8'h33) begin
            miscompares++;
            $display("FAIL busy_valid_ones: got %0d want %0d", ones, 8'h33);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_half_code();
        test_endpoints();
        test_back_to_back();
        test_abort();
        test_valid_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
